// File: rtl/sram_fifo_tx_pkg.sv
// sram_fifo_tx_pkg
//   Shared definitions for the serial FIFO transmitter:
//   - state encodings (3-bit, IDLE=0 .. STOP=5)
//   - idle line level of the serial output
//   - width helper for counters sized by $clog2 with a floor of 1 bit
package sram_fifo_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a count of n: $clog2(n), never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_fifo_tx_bit_timer.sv
// bit_timer
//   Free-running bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     clear     in   restart the period (asserted on every parent state change)
//     tick      out  high on the last cycle of each bit period
//     tick_next out  value tick will have in the next cycle; lets the parent
//                    register outputs that line up with the last cycle
module bit_timer
  import sram_fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_count;
  logic [TW-1:0] w_count_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_next = r_count + TW'(1);
    if (clear || (r_count == LAST)) begin
      w_count_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign tick      = (r_count == LAST);
  assign tick_next = (w_count_next == LAST);

endmodule

// File: rtl/sram_fifo_tx.sv
// sram_fifo_tx
//   Drains an 8-bit SRAM FIFO one packet at a time and shifts each packet out
//   LSB first, framed by a start bit (0) and a stop bit (1), each bit held for
//   CLKS_PER_BIT cycles. The FIFO has no protection of its own, so every read
//   is gated by fifo_empty.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     enable     in   permits starting a new frame (checked only in IDLE and
//                     on the last stop-bit cycle)
//     fifo_empty in   FIFO holds no unread packet
//     fifo_read  out  one-cycle read strobe to the FIFO
//     fifo_data  in   FIFO output packet, valid the cycle after fifo_read
//     tx         out  serial line, idles high
//     busy       out  high whenever the FSM is not idle
//     done       out  one-cycle pulse on the final stop-bit cycle
module sram_fifo_tx
  import sram_fifo_tx_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            fifo_empty,
  output logic            fifo_read,
  input  logic [BITS-1:0] fifo_data,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int CW = cnt_width(BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [BITS-1:0] r_shift;
  logic [BITS-1:0] w_shift_next;
  logic [CW-1:0]   r_bit_cnt;
  logic [CW-1:0]   w_bit_cnt_next;
  logic            r_tx;
  logic            r_fifo_read;
  logic            r_busy;
  logic            r_done;
  logic            w_tx_next;
  logic            w_done_next;
  logic            w_tick;
  logic            w_tick_next;
  logic            w_state_change;
  logic            w_start_ok;

  assign w_start_ok     = enable && !fifo_empty;
  assign w_state_change = (w_state_next != r_state);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_state_change),
    .tick     (w_tick),
    .tick_next(w_tick_next)
  );

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_START;
      S_START: if (w_tick) w_state_next = S_DATA;
      S_DATA:  if (w_tick && (r_bit_cnt == LAST_BIT)) w_state_next = S_STOP;
      S_STOP:  if (w_tick) w_state_next = w_start_ok ? S_FETCH : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: packet captured in LOAD (the cycle fifo_data is valid), then
  // shifted right once per completed data bit so bit 0 is always the one on air.
  always_comb begin
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    if (w_state_change) begin
      w_bit_cnt_next = '0;
    end
    if (r_state == S_LOAD) begin
      w_shift_next = fifo_data;
    end else if ((r_state == S_DATA) && w_tick && !w_state_change) begin
      w_bit_cnt_next = r_bit_cnt + CW'(1);
      w_shift_next   = r_shift >> 1;
    end
  end

  // Outputs are registered from the next state so they change together with
  // the state register rather than a cycle later.
  always_comb begin
    w_tx_next = IDLE_LEVEL;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = IDLE_LEVEL;
    endcase
    w_done_next = (w_state_next == S_STOP) && w_tick_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_tx        <= IDLE_LEVEL;
      r_fifo_read <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_tx        <= w_tx_next;
      r_fifo_read <= (w_state_next == S_FETCH);
      r_busy      <= (w_state_next != S_IDLE);
      r_done      <= w_done_next;
    end
  end

  assign tx        = r_tx;
  assign fifo_read = r_fifo_read;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
